// File: rtl/adc_channel_sequencer.sv
// -----------------------------------------------------------------------------
// adc_channel_sequencer
//
// Per-frame ADC channel sequencer sitting directly upstream of the frame FIFO.
// Each FRAME_TRIG walks the enabled channels in ascending order. For each one
// it drives the mux select, waits for the mux to settle, pulses ADC_START and
// collects the conversion result. Every result goes out as a one-cycle
// RESULT/DONE/ATMCHSEL word, and LASTWORD marks the final channel of the frame.
//
// Parameters
//   ADC_BITS     ADC output width (1..16), zero-extended into RESULT
//   SETTLE_CYC   mux settle cycles before ADC_START (>=1)
//   TIMEOUT_CYC  max cycles waiting for ADC_EOC after ADC_START (>=1)
//
// Ports
//   SAMPLE_CLK   in   block clock
//   NRST_sync    in   asynchronous active-low reset
//   ENSAMP_sync  in   sampling enable; low aborts to idle synchronously
//   CHEN         in   [7:0] channel enable mask, latched at trigger
//   FRAME_TRIG   in   one-cycle frame start tick
//   ADC_DOUT     in   conversion result, valid with ADC_EOC
//   ADC_EOC      in   end-of-conversion pulse
//   ADC_START    out  one-cycle conversion start pulse
//   ADC_CHSEL    out  [2:0] ADC mux channel select
//   RESULT       out  [15:0] sample word to FIFO (holds between words)
//   DONE         out  one-cycle FIFO write strobe
//   ATMCHSEL     out  [7:0] one-hot channel of RESULT, valid with DONE
//   LASTWORD     out  high with DONE on the last channel of the frame
//   SEQ_BUSY     out  high whenever the sequencer is not idle
//   FRAME_MISS   out  toggles when a trigger is dropped while busy
//   ADC_TIMEOUT  out  toggles when ADC_EOC did not arrive in time
// -----------------------------------------------------------------------------
module adc_channel_sequencer #(
  parameter int ADC_BITS    = 12,
  parameter int SETTLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                SAMPLE_CLK,
  input  logic                NRST_sync,
  input  logic                ENSAMP_sync,
  input  logic [7:0]          CHEN,
  input  logic                FRAME_TRIG,
  input  logic [ADC_BITS-1:0] ADC_DOUT,
  input  logic                ADC_EOC,
  output logic                ADC_START,
  output logic [2:0]          ADC_CHSEL,
  output logic [15:0]         RESULT,
  output logic                DONE,
  output logic [7:0]          ATMCHSEL,
  output logic                LASTWORD,
  output logic                SEQ_BUSY,
  output logic                FRAME_MISS,
  output logic                ADC_TIMEOUT
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    EMIT
  } state_t;

  state_t          state_reg, state_next;
  logic [7:0]      chen_reg, chen_next;
  logic [2:0]      chsel_reg, chsel_next;
  logic [SW-1:0]   settle_reg, settle_next;
  logic [WW-1:0]   wait_reg, wait_next;
  logic            start_reg, start_next;
  logic [15:0]     result_reg, result_next;
  logic            done_reg, done_next;
  logic [7:0]      atm_reg, atm_next;
  logic            last_reg, last_next;
  logic            busy_reg;
  logic            miss_reg, miss_next;
  logic            tmo_reg, tmo_next;

  // Enabled channels strictly above the current one. Empty means the
  // current channel is the last of the frame.
  logic [7:0]      higher_bits;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_higher
      assign higher_bits[gi] = chen_reg[gi] && (3'(gi) > chsel_reg);
    end
  endgenerate

  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_next  = state_reg;
    chen_next   = chen_reg;
    chsel_next  = chsel_reg;
    settle_next = settle_reg;
    wait_next   = wait_reg;
    start_next  = 1'b0;
    result_next = result_reg;
    done_next   = 1'b0;
    atm_next    = 8'h00;
    last_next   = 1'b0;
    miss_next   = miss_reg;
    tmo_next    = tmo_reg;

    if (!ENSAMP_sync) begin
      // Abort: no partial-frame word, select parked at 0, toggles hold
      state_next = IDLE;
      chsel_next = 3'd0;
    end else begin
      // A trigger is only accepted from IDLE. That includes the EMIT cycle
      // that is about to return to IDLE, so a trigger there is a miss too.
      if (FRAME_TRIG && (state_reg != IDLE)) begin
        miss_next = ~miss_reg;
      end

      unique case (state_reg)
        IDLE: begin
          if (FRAME_TRIG && (CHEN != 8'h00)) begin
            chen_next   = CHEN;
            chsel_next  = lowest_set(CHEN);
            settle_next = SW'(1);
            state_next  = SETTLE;
          end
        end

        SETTLE: begin
          // settle_reg counts the settle cycles elapsed so far, starting at 1
          if (settle_reg >= SETTLE_LAST) begin
            state_next = CONVERT;
            start_next = 1'b1;
            wait_next  = '0;
          end else begin
            settle_next = settle_reg + SW'(1);
          end
        end

        CONVERT: begin
          // wait_reg is 0 in the ADC_START cycle, so an EOC there is ignored
          if ((wait_reg != '0) && ADC_EOC) begin
            result_next = 16'(ADC_DOUT);
            state_next  = EMIT;
            done_next   = 1'b1;
            atm_next    = 8'b1 << chsel_reg;
            last_next   = (higher_bits == 8'h00);
          end else if (wait_reg >= WAIT_LAST) begin
            result_next = 16'h0000;
            tmo_next    = ~tmo_reg;
            state_next  = EMIT;
            done_next   = 1'b1;
            atm_next    = 8'b1 << chsel_reg;
            last_next   = (higher_bits == 8'h00);
          end else begin
            wait_next = wait_reg + WW'(1);
          end
        end

        EMIT: begin
          if (higher_bits != 8'h00) begin
            chsel_next  = lowest_set(higher_bits);
            settle_next = SW'(1);
            state_next  = SETTLE;
          end else begin
            state_next = IDLE;
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state_reg  <= IDLE;
      chen_reg   <= 8'h00;
      chsel_reg  <= 3'd0;
      settle_reg <= '0;
      wait_reg   <= '0;
      start_reg  <= 1'b0;
      result_reg <= 16'h0000;
      done_reg   <= 1'b0;
      atm_reg    <= 8'h00;
      last_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      miss_reg   <= 1'b0;
      tmo_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      chen_reg   <= chen_next;
      chsel_reg  <= chsel_next;
      settle_reg <= settle_next;
      wait_reg   <= wait_next;
      start_reg  <= start_next;
      result_reg <= result_next;
      done_reg   <= done_next;
      atm_reg    <= atm_next;
      last_reg   <= last_next;
      busy_reg   <= (state_next != IDLE);
      miss_reg   <= miss_next;
      tmo_reg    <= tmo_next;
    end
  end

  assign ADC_START   = start_reg;
  assign ADC_CHSEL   = chsel_reg;
  assign RESULT      = result_reg;
  assign DONE        = done_reg;
  assign ATMCHSEL    = atm_reg;
  assign LASTWORD    = last_reg;
  assign SEQ_BUSY    = busy_reg;
  assign FRAME_MISS  = miss_reg;
  assign ADC_TIMEOUT = tmo_reg;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc_channel_sequencer
//
// Bench for adc_channel_sequencer. The bench plays the ADC: it answers each
// ADC_START with an EOC after a chosen or random delay, or with no EOC at all.
// A frame model predicts every output word from the channel list, and the
// expected timing follows the trigger/settle/EOC latency rules.
// -----------------------------------------------------------------------------
module tb_adc_channel_sequencer;

  localparam int ADC_BITS = 12;
  localparam int SETTLE   = 2;
  localparam int TIMEOUT  = 255;

  logic                SAMPLE_CLK;
  logic                NRST_sync;
  logic                ENSAMP_sync;
  logic [7:0]          CHEN;
  logic                FRAME_TRIG;
  logic [ADC_BITS-1:0] ADC_DOUT;
  logic                ADC_EOC;
  logic                ADC_START;
  logic [2:0]          ADC_CHSEL;
  logic [15:0]         RESULT;
  logic                DONE;
  logic [7:0]          ATMCHSEL;
  logic                LASTWORD;
  logic                SEQ_BUSY;
  logic                FRAME_MISS;
  logic                ADC_TIMEOUT;

  adc_channel_sequencer #(
    .ADC_BITS    (ADC_BITS),
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .SAMPLE_CLK  (SAMPLE_CLK),
    .NRST_sync   (NRST_sync),
    .ENSAMP_sync (ENSAMP_sync),
    .CHEN        (CHEN),
    .FRAME_TRIG  (FRAME_TRIG),
    .ADC_DOUT    (ADC_DOUT),
    .ADC_EOC     (ADC_EOC),
    .ADC_START   (ADC_START),
    .ADC_CHSEL   (ADC_CHSEL),
    .RESULT      (RESULT),
    .DONE        (DONE),
    .ATMCHSEL    (ATMCHSEL),
    .LASTWORD    (LASTWORD),
    .SEQ_BUSY    (SEQ_BUSY),
    .FRAME_MISS  (FRAME_MISS),
    .ADC_TIMEOUT (ADC_TIMEOUT)
  );

  initial SAMPLE_CLK = 1'b0;
  always #5 SAMPLE_CLK = ~SAMPLE_CLK;

  int   errors = 0;
  int   checks = 0;
  logic exp_miss = 1'b0;
  logic exp_tmo  = 1'b0;
  logic [11:0] dout_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame. Outputs are sampled and inputs driven at the falling edge;
  // t counts cycles from the trigger cycle (t=0).
  //   delay: >0 fixed EOC delay, 0 random (occasional timeout), -1 never EOC
  //   miss_ch: channel whose START cycle also carries a stray trigger (-1 none)
  //   miss_last: stray trigger in the last DONE cycle
  //   abort_ch: drop ENSAMP_sync in this channel's START cycle (-1 none)
  task automatic run_frame(input logic [7:0] mask, input int delay, input int miss_ch,
                           input bit miss_last, input int abort_ch);
    int          chs[$];
    int          t, exp_start, exp_done, eoc_t, idle_t, abort_t, budget, d;
    logic [15:0] exp_res;
    logic [11:0] dout;
    bit          finished;

    for (int c = 0; c < 8; c++) if (mask[c]) chs.push_back(c);
    @(negedge SAMPLE_CLK);
    CHEN = mask; FRAME_TRIG = 1'b1; ENSAMP_sync = 1'b1; ADC_EOC = 1'b0;
    t = 0; exp_start = 1 + SETTLE; exp_done = -1; eoc_t = -1;
    idle_t = -1; abort_t = -1; finished = 0; exp_res = 16'h0; dout = 12'h0;
    budget = 8 * (SETTLE + TIMEOUT + 4) + 10;

    while (!finished && t < budget) begin
      @(negedge SAMPLE_CLK);
      t++;
      FRAME_TRIG = 1'b0; ADC_EOC = 1'b0; ENSAMP_sync = 1'b1;
      CHEN = 8'($urandom());      // mid-frame mask changes must be ignored
      ADC_DOUT = 12'($urandom());

      if (t == abort_t) begin
        check("abort_busy",  SEQ_BUSY,  0);
        check("abort_done",  DONE,      0);
        check("abort_chsel", ADC_CHSEL, 0);
        check("abort_start", ADC_START, 0);
        check("abort_last",  LASTWORD,  0);
        finished = 1;
      end else if (t == idle_t) begin
        check("idle_busy", SEQ_BUSY, 0);
        check("idle_done", {DONE, LASTWORD, ATMCHSEL}, 0);
        check("frame_miss", FRAME_MISS, exp_miss);
        finished = 1;
      end else begin
        if (t == eoc_t) begin
          ADC_EOC = 1'b1; ADC_DOUT = dout;
        end

        if (ADC_START) begin
          check("start_time", t, exp_start);
          if (chs.size() == 0) check("extra_start", 1, 0);
          else begin
            check("start_chsel", ADC_CHSEL, chs[0]);
            if (chs[0] == miss_ch) begin
              FRAME_TRIG = 1'b1; exp_miss = ~exp_miss;
            end
            if (chs[0] == abort_ch) begin
              ENSAMP_sync = 1'b0; abort_t = t + 1;
            end else begin
              d = delay;
              if (d == 0) d = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(1, 6));
              if (d < 0) begin
                eoc_t = -1; exp_done = t + TIMEOUT + 1; exp_res = 16'h0000; exp_tmo = ~exp_tmo;
              end else begin
                dout = (dout_q.size() > 0) ? dout_q.pop_front() : 12'($urandom());
                eoc_t = t + d; exp_done = eoc_t + 1; exp_res = {4'h0, dout};
                // EOC in the START cycle itself must be ignored
                if (delay == 0 && $urandom_range(0, 1) == 1) ADC_EOC = 1'b1;
              end
            end
          end
        end

        if (DONE) begin
          check("done_time", t, exp_done);
          if (chs.size() == 0) check("extra_done", 1, 0);
          else begin
            $display("word t=%0d ch=%0d atm=%h result=%h last=%b", t, chs[0], ATMCHSEL, RESULT, LASTWORD);
            check("atmchsel", ATMCHSEL, 8'(1) << chs[0]);
            check("result", RESULT, exp_res);
            check("lastword", LASTWORD, (chs.size() == 1) ? 1 : 0);
            check("timeout_tgl", ADC_TIMEOUT, exp_tmo);
            void'(chs.pop_front());
            exp_start = t + SETTLE + 1;
            if (chs.size() == 0) begin
              idle_t = t + 1;
              if (miss_last) begin
                FRAME_TRIG = 1'b1; exp_miss = ~exp_miss;
              end
            end
          end
        end else if (t == exp_done) begin
          check("done_missing", DONE, 1);
        end
      end
    end
    if (!finished) check("frame_complete", 0, 1);

    // Quiet period: nothing may start or emit without a trigger
    for (int i = 0; i < 3; i++) begin
      @(negedge SAMPLE_CLK);
      FRAME_TRIG = 1'b0; ADC_EOC = 1'b0; ENSAMP_sync = 1'b1;
      check("quiet", {SEQ_BUSY, DONE, ADC_START}, 0);
    end
  endtask

  initial begin
    NRST_sync = 1'b0; ENSAMP_sync = 1'b1; CHEN = 8'h00; FRAME_TRIG = 1'b0;
    ADC_DOUT = '0; ADC_EOC = 1'b0;
    repeat (2) @(negedge SAMPLE_CLK);
    check("reset_a", {ADC_START, ADC_CHSEL, DONE, ATMCHSEL, LASTWORD, SEQ_BUSY, FRAME_MISS, ADC_TIMEOUT}, 0);
    check("reset_result", RESULT, 0);
    NRST_sync = 1'b1;

    // Trigger with an empty mask does nothing and is not a miss
    @(negedge SAMPLE_CLK);
    CHEN = 8'h00; FRAME_TRIG = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge SAMPLE_CLK);
      FRAME_TRIG = 1'b0;
      check("empty_mask", {SEQ_BUSY, ADC_START, FRAME_MISS}, 0);
    end

    // Two channels, fixed EOC delay, directed data
    dout_q.push_back(12'hABC); dout_q.push_back(12'h123);
    run_frame(8'h05, 3, -1, 0, -1);
    // Single top channel: START at cycle 3, CHSEL 7
    run_frame(8'h80, 2, -1, 0, -1);
    // No EOC: timeout word 256 cycles after START
    run_frame(8'h01, -1, -1, 0, -1);
    // All channels with a stray trigger during channel 3
    run_frame(8'hFF, 0, 3, 0, -1);
    // Abort in CONVERT of channel 2, then a clean restart
    run_frame(8'h0F, 0, -1, 0, 2);
    run_frame(8'h0F, 0, -1, 0, -1);

    // Asynchronous reset in the middle of SETTLE
    @(negedge SAMPLE_CLK);
    CHEN = 8'h0C; FRAME_TRIG = 1'b1;
    @(negedge SAMPLE_CLK);
    FRAME_TRIG = 1'b0;
    check("pre_reset_busy", SEQ_BUSY, 1);
    #2 NRST_sync = 1'b0;
    #1;
    check("async_reset_a", {ADC_START, ADC_CHSEL, DONE, ATMCHSEL, LASTWORD, SEQ_BUSY, FRAME_MISS, ADC_TIMEOUT}, 0);
    check("async_reset_result", RESULT, 0);
    exp_miss = 1'b0; exp_tmo = 1'b0;
    repeat (2) @(negedge SAMPLE_CLK);
    NRST_sync = 1'b1;
    run_frame(8'h0C, 0, -1, 0, -1);

    // Random frames
    for (int f = 0; f < 12; f++) begin
      run_frame(8'($urandom_range(1, 255)), 0, int'($urandom_range(0, 8)) - 1,
                bit'($urandom_range(0, 1)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
